// File: rtl/xpb_pkg.sv
// ============================================================================
// xpb_pkg : shared widths and FSM encoding for the XPB table writer
// Revision : 1.0
// ============================================================================
`default_nettype none

package xpb_pkg;

  localparam int XPB_WIDTH    = 1024;
  localparam int XPB_SEL_BITS = 5;
  localparam int XPB_ENTRIES  = 2 ** XPB_SEL_BITS;

  typedef logic [2:0] xpb_state_t;

  localparam xpb_state_t ST_IDLE  = 3'd0;
  localparam xpb_state_t ST_WRITE = 3'd1;
  localparam xpb_state_t ST_ADD   = 3'd2;
  localparam xpb_state_t ST_RED   = 3'd3;
  localparam xpb_state_t ST_DONE  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/xpb_modadd.sv
// ============================================================================
// xpb_modadd : registered (a + b) followed by one conditional subtract of n
// Revision : 1.0
// ============================================================================
`default_nettype none

module xpb_modadd
  import xpb_pkg::*;
#(
  parameter int WIDTH = XPB_WIDTH
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH:0]   sum,
  output logic [WIDTH-1:0] red
);

  logic [WIDTH:0] r_sum;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  // The extra bit keeps the carry of a + b so the compare against n is exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
    end else if (load) begin
      r_sum <= {1'b0, a} + {1'b0, b};
    end
  end

  assign w_ge   = (r_sum >= {1'b0, n});
  assign w_diff = r_sum - {1'b0, n};
  assign red    = w_ge ? w_diff[WIDTH-1:0] : r_sum[WIDTH-1:0];
  assign sum    = r_sum;

endmodule

`default_nettype wire

// File: rtl/xpb_table_writer.sv
// ============================================================================
// xpb_table_writer : streams the table (j*B) mod N, j = 0 .. 2**SEL_BITS-1
// Optional readback RAM: define XPB_TABLE_READBACK_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module xpb_table_writer
  import xpb_pkg::*;
#(
  parameter int WIDTH    = XPB_WIDTH,
  parameter int SEL_BITS = XPB_SEL_BITS
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    base,
  input  logic [WIDTH-1:0]    modulus,
  output logic                busy,
  output logic                done,
  output logic                wr_en,
  output logic [SEL_BITS-1:0] wr_addr,
  output logic [WIDTH-1:0]    wr_data
`ifdef XPB_TABLE_READBACK_EN
  ,
  input  logic [SEL_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]    rd_data
`endif
);

  localparam logic [SEL_BITS-1:0] C_LAST_IDX = '1;

  xpb_state_t          r_state;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_n;
  logic [WIDTH-1:0]    r_acc;
  logic [SEL_BITS-1:0] r_idx;
  logic [SEL_BITS-1:0] r_wr_addr;
  logic [WIDTH-1:0]    w_red;
  logic [WIDTH:0]      w_unused_sum;

  xpb_modadd #(
    .WIDTH (WIDTH)
  ) u_modadd (
    .clk  (clk),
    .rst  (rst),
    .load (r_state == ST_ADD),
    .a    (r_acc),
    .b    (r_b),
    .n    (r_n),
    .sum  (w_unused_sum),
    .red  (w_red)
  );

  // acc only changes on the RED->WRITE step, so it doubles as the held write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_b       <= '0;
      r_n       <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_wr_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_b       <= base;
            r_n       <= modulus;
            r_acc     <= '0;
            r_idx     <= '0;
            r_wr_addr <= '0;
            r_state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (r_idx == C_LAST_IDX) begin
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx + SEL_BITS'(1);
            r_state <= ST_ADD;
          end
        end
        ST_ADD:  r_state <= ST_RED;
        ST_RED: begin
          r_acc     <= w_red;
          r_wr_addr <= r_idx;
          r_state   <= ST_WRITE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == ST_WRITE) || (r_state == ST_ADD) || (r_state == ST_RED);
  assign done    = (r_state == ST_DONE);
  assign wr_en   = (r_state == ST_WRITE);
  assign wr_addr = r_wr_addr;
  assign wr_data = r_acc;

`ifdef XPB_TABLE_READBACK_EN
  // Storage is intentionally left out of reset; reads see pre-write contents.
  logic [WIDTH-1:0] r_mem [2**SEL_BITS];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xpb_table_writer.sv
// ============================================================================
// tb_xpb_table_writer : self-checking bench for xpb_table_writer
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_xpb_table_writer;

  localparam int W  = 1024;
  localparam int SB = 5;
  localparam int NE = 32;
  localparam int PW = W + SB + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  base;
  logic [W-1:0]  modulus;
  logic          busy;
  logic          done;
  logic          wr_en;
  logic [SB-1:0] wr_addr;
  logic [W-1:0]  wr_data;
`ifdef XPB_TABLE_READBACK_EN
  logic [SB-1:0] rd_addr;
  logic [W-1:0]  rd_data;
`endif

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [W-1:0]  cap [NE];

  always #5 clk = ~clk;

  xpb_table_writer #(
    .WIDTH    (W),
    .SEL_BITS (SB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .base    (base),
    .modulus (modulus),
    .busy    (busy),
    .done    (done),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
`ifdef XPB_TABLE_READBACK_EN
    ,
    .rd_addr (rd_addr),
    .rd_data (rd_data)
`endif
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got hi=%h lo=%h, required hi=%h lo=%h",
               name, act[W-1:W-64], act[63:0], exp[W-1:W-64], exp[63:0]);
    end
  endtask

  // Reference: entry j is simply (j*B) mod N computed with wide arithmetic.
  function automatic logic [W-1:0] ref_entry(input int j, input logic [W-1:0] b,
                                             input logic [W-1:0] n);
    logic [PW-1:0] p;
    p = PW'(b) * PW'(j);
    p = p % PW'(n);
    return p[W-1:0];
  endfunction

  // One generation pass, checked every cycle against the cycle-level timing rules.
  task automatic run(input logic [W-1:0] b, input logic [W-1:0] n,
                     input int rst_cyc, input int stray_cyc, input logic [W-1:0] b2);
    int            k;
    int            ph;
    logic          ew, eb, ed;
    logic [SB-1:0] ea;
    logic [W-1:0]  edata;
    bit            aborted;
    @(negedge clk);
    base    = b;
    modulus = n;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    base    = ~b;
    modulus = ~n;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      aborted = (rst_cyc > 0) && (c > rst_cyc);
      k  = (c - 1) / 3;
      ph = (c - 1) % 3;
      if (aborted) begin
        {ew, eb, ed} = 3'b000;
        ea    = '0;
        edata = '0;
      end else begin
        ew    = (c <= 94) && (ph == 0);
        eb    = (c <= 94);
        ed    = (c == 95);
        ea    = (k > NE - 1) ? SB'(NE - 1) : SB'(k);
        edata = ref_entry((k > NE - 1) ? NE - 1 : k, b, n);
      end
      chk($sformatf("ctl{wr_en,busy,done} c%0d", c), W'({wr_en, busy, done}), W'({ew, eb, ed}));
      chk($sformatf("wr_addr c%0d", c), W'(wr_addr), W'(ea));
      chk($sformatf("wr_data c%0d", c), wr_data, edata);
      if (wr_en) cap[wr_addr] = wr_data;
      if (c == stray_cyc) begin
        start = 1'b1;
        base  = b2;
      end else begin
        start = 1'b0;
      end
      rst = (c == rst_cyc);
    end
  endtask

  typedef struct {
    logic [W-1:0] b;
    logic [W-1:0] n;
    int           idx;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vt [10];
  logic [W-1:0] nmax;
  logic [W-1:0] rn;
  logic [W-1:0] rb;

  initial begin
    nmax = '1;
    vt[0] = '{W'(10), W'(97),  1, W'(10)};
    vt[1] = '{W'(10), W'(97), 10, W'(3)};
    vt[2] = '{W'(10), W'(97), 31, W'(19)};
    vt[3] = '{W'(10), W'(97),  0, W'(0)};
    vt[4] = '{W'(0),  W'(97),  0, W'(0)};
    vt[5] = '{W'(0),  W'(97), 17, W'(0)};
    vt[6] = '{W'(0),  W'(97), 31, W'(0)};
    vt[7] = '{nmax - W'(1), nmax,  0, W'(0)};
    vt[8] = '{nmax - W'(1), nmax,  1, nmax - W'(1)};
    vt[9] = '{nmax - W'(1), nmax, 31, nmax - W'(31)};

    // Reset with start held high: reset must win.
    rst     = 1'b1;
    start   = 1'b1;
    base    = W'(5);
    modulus = W'(7);
`ifdef XPB_TABLE_READBACK_EN
    rd_addr = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ctl", W'({wr_en, busy, done}), W'(0));
    chk("reset wr_addr", W'(wr_addr), W'(0));
    chk("reset wr_data", wr_data, W'(0));
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle after reset ctl", W'({wr_en, busy, done}), W'(0));

    for (int i = 0; i < 10; i++) begin
      if (i == 0 || vt[i].b != vt[i-1].b || vt[i].n != vt[i-1].n)
        run(vt[i].b, vt[i].n, -1, -1, W'(0));
      chk($sformatf("table vec%0d entry%0d", i, vt[i].idx), cap[vt[i].idx], vt[i].exp);
    end

    // Stray start during generation with a different base is ignored.
    run(W'(10), W'(97), -1, 20, W'(55));
    for (int j = 0; j < NE; j++)
      chk($sformatf("stray-start entry%0d", j), cap[j], ref_entry(j, W'(10), W'(97)));

    // Abort just after entry 10, then a clean restart.
    run(W'(23), W'(97), 31, -1, W'(0));
    repeat (3) @(negedge clk);
    chk("post-abort idle ctl", W'({wr_en, busy, done}), W'(0));
    run(W'(23), W'(97), -1, -1, W'(0));
    chk("restart entry31", cap[31], ref_entry(31, W'(23), W'(97)));

    for (int r = 0; r < 4; r++) begin
      if (r < 2) begin
        for (int i = 0; i < W / 32; i++) begin
          rn[i*32 +: 32] = $urandom;
          rb[i*32 +: 32] = $urandom;
        end
      end else begin
        rn = W'($urandom_range(2, 5000));
        rb = W'($urandom);
      end
      if (rn == '0) rn = W'(1);
      rb = rb % rn;
      run(rb, rn, -1, -1, W'(0));
    end

`ifdef XPB_TABLE_READBACK_EN
    run(W'(10), W'(97), -1, -1, W'(0));
    @(negedge clk);
    rd_addr = SB'(31);
    @(negedge clk);
    chk("readback entry31", rd_data, W'(19));
    for (int j = 0; j < NE; j++) begin
      rd_addr = SB'(j);
      @(negedge clk);
      chk($sformatf("readback entry%0d", j), rd_data, ref_entry(j, W'(10), W'(97)));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/xpb_table_writer.md
XPB_TABLE_WRITER -- requirements
Module: xpb_table_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 1024, which sets the table-entry and operand width in bits.
REQ-002 SHALL have parameter SEL_BITS, default 5, which sets the table index width (2**SEL_BITS entries).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to generate the table.
REQ-006 SHALL have port base, input, WIDTH bits: the XPB base value B, sampled on an accepted start.
REQ-007 SHALL have port modulus, input, WIDTH bits: the modulus N, sampled on an accepted start.
REQ-008 SHALL have port busy, output, 1 bit: high while generation is in progress.
REQ-009 SHALL have port done, output, 1 bit: a one-cycle pulse when generation completes.
REQ-010 SHALL have port wr_en, output, 1 bit: table write strobe.
REQ-011 SHALL have port wr_addr, output, SEL_BITS bits: table write index j.
REQ-012 SHALL have port wr_data, output, WIDTH bits: table entry (j*B) mod N.
REQ-013 SHALL have ports rd_addr (input, SEL_BITS bits) and rd_data (output, WIDTH bits), present only under XPB_TABLE_READBACK_EN.

Function
REQ-014 SHALL use FSM states IDLE, WRITE, ADD, RED and DONE.
REQ-015 In IDLE, start=1 SHALL register base and modulus, clear the accumulator acc to 0, set index idx to 0 and move to WRITE.
REQ-016 In WRITE, wr_en SHALL be 1, wr_addr SHALL equal idx and wr_data SHALL equal acc.
REQ-017 From WRITE, if idx == 2**SEL_BITS-1 the FSM SHALL go to DONE; otherwise idx SHALL increment and the FSM SHALL go to ADD.
REQ-018 In ADD, the FSM SHALL register sum = acc + B at WIDTH+1 bits, with no truncation, and go to RED.
REQ-019 In RED, the FSM SHALL set acc = (sum >= N) ? sum - N : sum (one conditional subtract) and go to WRITE.
REQ-020 Timing SHALL be: entry 0 written on cycle 1 after start, entry k on cycle 1+3k; entry 31 on cycle 94 for the default sizes; done=1 on cycle 95, then back to IDLE.
REQ-021 Outputs SHALL be correct only for B < N and N != 0; other inputs give undefined data, but the FSM sequence and timing SHALL be unchanged.
REQ-022 busy SHALL be 1 in WRITE, ADD and RED, and 0 in IDLE and DONE.
REQ-023 start while not in IDLE SHALL be ignored, and changes to base or modulus after acceptance SHALL have no effect.
REQ-024 wr_en SHALL be 0 in every state except WRITE; wr_addr and wr_data hold their last values when wr_en=0.

Reset
REQ-025 rst=1 SHALL force IDLE and zero busy, done, wr_en, wr_addr, wr_data, acc, idx and the registered operands on the next edge.
REQ-026 Reset mid-generation SHALL abort with no further writes; readback storage SHALL NOT be cleared.
REQ-027 rst SHALL take priority over start in the same cycle.

Configuration
REQ-028 With XPB_TABLE_READBACK_EN defined, the block SHALL contain a 2**SEL_BITS x WIDTH storage array written by wr_en/wr_addr/wr_data; rd_data SHALL equal entry[rd_addr] registered, with 1-cycle latency.
REQ-029 With XPB_TABLE_READBACK_EN defined, a read and a write to the same address in the same cycle SHALL return the old data.
REQ-030 Without XPB_TABLE_READBACK_EN, rd_addr, rd_data and the storage array SHALL be absent; entries are only streamed on the write port.

Structure
REQ-031 The FSM state enum and the width constants (WIDTH default, SEL_BITS default, entry count) SHALL live in the shared package xpb_pkg.
REQ-032 The add/conditional-subtract datapath SHALL be one sub-module, xpb_modadd (inputs a, b, n; outputs sum and reduced result).

Verification
REQ-033 N=97, B=10, start -> 32 writes at cycles 1,4,...,94; entry1=10, entry10=3, entry31=19; done at cycle 95.
REQ-034 N=97, B=0 -> all 32 entries = 0; timing identical to REQ-033.
REQ-035 N=2**1024-1, B=N-1 -> entry0=0, entry j = N-j for j>=1, entry31 = N-31 (checks the WIDTH+1 carry).
REQ-036 A second start at cycle 20 with different B -> ignored; all entries match the first B.
REQ-037 rst asserted at cycle 31 (just after entry 10 is written) -> no writes after it, busy=0 on the next edge, done never pulses; a restart gives a full correct table.
REQ-038 XPB_TABLE_READBACK_EN defined, after the REQ-033 run, rd_addr=31 -> rd_data=19 one cycle later.
